// File: rtl/spi_var_pkg.sv
// -----------------------------------------------------------------------------
// spi_var_pkg
// Shared types and constants for the SPI variable-readout slave.
//   state_t        : frame-handling FSM states
//   CMD_PREFIX_DEF : upper six command bits of a valid read command (0xA0-0xA2)
//   VAR_W / SEL_W  : variable byte width and mux select width
//   VAR_SEL_MAX    : highest select value that maps to a real mux input
//   cmd_is_read()  : decodes whether a command byte is a valid read request
// -----------------------------------------------------------------------------
package spi_var_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CMD       = 3'd2,
        ST_DATA      = 3'd3,
        ST_IGNORE    = 3'd4
    } state_t;

    localparam logic [5:0] CMD_PREFIX_DEF = 6'b101000;
    localparam int         VAR_W          = 8;
    localparam int         SEL_W          = 2;

    localparam logic [SEL_W-1:0] VAR_SEL_MAX = 2'd2;

    // A read command carries the fixed prefix in its top six bits and a
    // select that addresses one of the three mux inputs.
    function automatic logic cmd_is_read(input logic [VAR_W-1:0] c,
                                         input logic [5:0]       prefix);
        return (c[7:2] == prefix) && (c[SEL_W-1:0] <= VAR_SEL_MAX);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain through a SYNC_STAGES
// flip-flop chain and flags its rising/falling transitions.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : raw asynchronous pin
//   dout     : synchronized level
//   rise     : one-clk event, synchronized level went 0 -> 1
//   fall     : one-clk event, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {SYNC_STAGES{RST_VAL}};
            prev_reg <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign dout = sync_reg[SYNC_STAGES-1];
    assign rise = dout & ~prev_reg;
    assign fall = ~dout & prev_reg;

endmodule

// File: rtl/spi_var_slave.sv
// -----------------------------------------------------------------------------
// spi_var_slave
// SPI mode-0 slave: receives a one-byte read command, drives the 3-to-1
// variable mux select from it, and streams the selected byte back on MISO
// (repeating the byte, re-sampled each time, until chip select rises).
// All SPI pins are oversampled in clk; SCLK is never used as a clock.
//   clk, rst     : 50 MHz system clock, asynchronous active-high reset
//   spi_sclk     : SPI clock (idle low)          spi_cs_n : chip select (low)
//   spi_mosi     : master data out               spi_miso : slave data out
//   spi_miso_oe  : MISO pad enable, high while a frame is in progress
//   var_sel      : mux select (0=in1, 1=in2, 2=in3)
//   var_data     : mux output byte (combinational from var_sel)
//   cmd_valid    : one-clk pulse when a full command byte has arrived
//   cmd          : last complete command byte
// -----------------------------------------------------------------------------
module spi_var_slave
    import spi_var_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] CMD_PREFIX  = CMD_PREFIX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [SEL_W-1:0] var_sel,
    input  logic [VAR_W-1:0] var_data,
    output logic             cmd_valid,
    output logic [VAR_W-1:0] cmd
);

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n resets to 0 so that a pin already low at reset release is never
    // mistaken for an idle bus; WAIT_IDLE only leaves on a genuine high.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // MOSI has the same depth as SCLK so the sampled bit lines up with the
    // SCLK rising event.
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM and datapath registers
    // ------------------------------------------------------------------
    state_t             state_reg,     state_next;
    logic [2:0]         bit_cnt_reg,   bit_cnt_next;
    logic [VAR_W-2:0]   rx_reg,        rx_next;
    logic [VAR_W-1:0]   tx_reg,        tx_next;
    logic               miso_reg,      miso_next;
    logic [VAR_W-1:0]   cmd_reg,       cmd_next;
    logic               cmd_valid_reg, cmd_valid_next;
    logic [SEL_W-1:0]   var_sel_reg,   var_sel_next;
    logic [VAR_W-1:0]   rx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_WAIT_IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            var_sel_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            miso_reg      <= miso_next;
            cmd_reg       <= cmd_next;
            cmd_valid_reg <= cmd_valid_next;
            var_sel_reg   <= var_sel_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        miso_next      = miso_reg;
        cmd_next       = cmd_reg;
        cmd_valid_next = 1'b0;
        var_sel_next   = var_sel_reg;
        rx_byte        = {rx_reg, mosi_s};

        // End of frame overrides any SCLK event in the same cycle; a
        // partially received command is simply dropped.
        if (cs_rise) begin
            state_next = ST_IDLE;
            miso_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_WAIT_IDLE: begin
                    miso_next = 1'b0;
                    // Bus is idle only with cs_n high and SCLK at rest.
                    if (cs_s && !sclk_s) begin
                        state_next = ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    miso_next = 1'b0;
                    if (cs_fall) begin
                        state_next   = ST_CMD;
                        bit_cnt_next = 3'd0;
                        rx_next      = '0;
                    end
                end

                ST_CMD: begin
                    miso_next = 1'b0;
                    if (sclk_rise) begin
                        rx_next      = rx_byte[VAR_W-2:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            cmd_next       = rx_byte;
                            cmd_valid_next = 1'b1;
                            if (cmd_is_read(rx_byte, CMD_PREFIX)) begin
                                var_sel_next = rx_byte[SEL_W-1:0];
                                state_next   = ST_DATA;
                            end else begin
                                state_next   = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    // The counter wraps after each byte, so every byte
                    // boundary re-samples var_data.
                    if (sclk_fall) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd0) begin
                            miso_next = var_data[VAR_W-1];
                            tx_next   = {var_data[VAR_W-2:0], 1'b0};
                        end else begin
                            miso_next = tx_reg[VAR_W-1];
                            tx_next   = {tx_reg[VAR_W-2:0], 1'b0};
                        end
                    end
                end

                ST_IGNORE: begin
                    miso_next = 1'b0;
                end

                default: begin
                    state_next = ST_WAIT_IDLE;
                    miso_next  = 1'b0;
                end
            endcase
        end
    end

    assign spi_miso    = miso_reg;
    assign spi_miso_oe = (state_reg == ST_CMD) || (state_reg == ST_DATA) ||
                         (state_reg == ST_IGNORE);
    assign var_sel     = var_sel_reg;
    assign cmd_valid   = cmd_valid_reg;
    assign cmd         = cmd_reg;

endmodule

// File: tb/tb_spi_var_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_var_slave
// Drives spi_var_slave as a mode-0 SPI master and compares received bytes,
// command register, select and cmd_valid pulse counts against a reference
// model derived from the command-decoding rules.
// -----------------------------------------------------------------------------
module tb_spi_var_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [1:0] var_sel;
    logic [7:0] var_data;
    logic       cmd_valid;
    logic [7:0] cmd;

    // System mux: in1..in3 on selects 0..2, select 3 reads zero.
    logic [7:0] vars [0:3];
    assign var_data = vars[var_sel];

    spi_var_slave dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .var_sel     (var_sel),
        .var_data    (var_data),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cv_count = 0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cv_count++;
    end

    // Reference model state
    logic [7:0] ref_cmd;
    logic [1:0] ref_sel;

    // Frame capture
    logic [7:0] rx_data [0:1];
    bit         cmd_miso_ok;
    logic       oe_in_frame;
    int         change_at;
    int         change_idx;
    logic [7:0] change_val;

    function automatic bit model_is_read(input logic [7:0] c);
        return (c[7:2] == 6'b101000) && (c[1:0] != 2'd3);
    endfunction

    function automatic void model_cmd(input logic [7:0] c);
        ref_cmd = c;
        if (model_is_read(c)) ref_sel = c[1:0];
    endfunction

    // One mode-0 bit: present MOSI, sample MISO just before SCLK rises.
    task automatic spi_bit(input logic b, input int hp, output logic m);
        spi_mosi = b;
        repeat (hp) @(negedge clk);
        m = spi_miso;
        spi_sclk = 1'b1;
        repeat (hp) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] c, input int nbytes, input int hp);
        logic m;
        cmd_miso_ok = 1'b1;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        oe_in_frame = spi_miso_oe;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(c[i], hp, m);
            if (m !== 1'b0) cmd_miso_ok = 1'b0;
        end
        for (int b = 0; b < nbytes; b++) begin
            rx_data[b] = 8'h00;
            for (int k = 0; k < 8; k++) begin
                spi_bit(1'($urandom_range(0, 1)), hp, m);
                rx_data[b] = {rx_data[b][6:0], m};
                if (b * 8 + k == change_at) vars[change_idx] = change_val;
            end
        end
        repeat (hp) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("frame cmd=%02h bytes=%0d hp=%0d rx0=%02h sel=%0d", c, nbytes, hp,
                 rx_data[0], var_sel);
    endtask

    // Compare a completed frame against the model (model already updated).
    task automatic check_frame(input string name, input logic [7:0] c,
                               input int nbytes, input int cv0,
                               input logic [7:0] exp0, input logic [7:0] exp1);
        checks++;
        if (cmd !== ref_cmd) begin
            failures++;
            $display("FAIL %s cmd: got %02h expected %02h", name, cmd, ref_cmd);
        end
        checks++;
        if (var_sel !== ref_sel) begin
            failures++;
            $display("FAIL %s var_sel: got %0d expected %0d", name, var_sel, ref_sel);
        end
        checks++;
        if (cv_count - cv0 != 1) begin
            failures++;
            $display("FAIL %s cmd_valid pulses: got %0d expected 1", name, cv_count - cv0);
        end
        checks++;
        if (!cmd_miso_ok) begin
            failures++;
            $display("FAIL %s miso during cmd: got nonzero expected 0 (cmd %02h)", name, c);
        end
        checks++;
        if (rx_data[0] !== exp0) begin
            failures++;
            $display("FAIL %s byte0: got %02h expected %02h", name, rx_data[0], exp0);
        end
        if (nbytes > 1) begin
            checks++;
            if (rx_data[1] !== exp1) begin
                failures++;
                $display("FAIL %s byte1: got %02h expected %02h", name, rx_data[1], exp1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        change_at = -1; change_idx = 0; change_val = 8'h00;
        for (int i = 0; i < 3; i++) vars[i] = 8'($urandom);
        vars[3] = 8'h00;
        ref_cmd = 8'h00; ref_sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, var_sel, cmd_valid, cmd} !== 13'd0) begin
            failures++;
            $display("FAIL reset outputs: got miso=%b oe=%b sel=%0d cv=%b cmd=%02h expected all 0",
                     spi_miso, spi_miso_oe, var_sel, cmd_valid, cmd);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (spi_miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL reset idle oe: got %b expected 0", spi_miso_oe);
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] c = 8'hA1;
        logic       m;
        bit         miso_zero = 1'b1;
        int         cv0;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 5; i--) spi_bit(c[i], 4, m);
        rst = 1'b1;
        ref_cmd = 8'h00; ref_sel = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, var_sel, cmd_valid, cmd} !== 13'd0) begin
            failures++;
            $display("FAIL midreset outputs: got miso=%b oe=%b sel=%0d cmd=%02h expected all 0",
                     spi_miso, spi_miso_oe, var_sel, cmd);
        end
        rst = 1'b0;
        cv0 = cv_count;
        for (int i = 4; i >= 0; i--) begin
            spi_bit(c[i], 4, m);
            if (m !== 1'b0) miso_zero = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            spi_bit(1'($urandom_range(0, 1)), 4, m);
            if (m !== 1'b0) miso_zero = 1'b0;
        end
        checks++;
        if (cv_count != cv0) begin
            failures++;
            $display("FAIL midreset cmd_valid: got %0d pulses expected 0", cv_count - cv0);
        end
        checks++;
        if (!miso_zero) begin
            failures++;
            $display("FAIL midreset miso: got nonzero expected 0");
        end
        checks++;
        if (var_sel !== 2'd0 || spi_miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL midreset sel/oe: got sel=%0d oe=%b expected 0/0", var_sel, spi_miso_oe);
        end
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        // Following full frame decodes normally.
        cv0 = cv_count;
        vars[2] = 8'($urandom);
        do_frame(8'hA2, 1, 4);
        model_cmd(8'hA2);
        check_frame("midreset_next", 8'hA2, 1, cv0, vars[ref_sel], 8'h00);
    endtask

    task automatic test_valid_read();
        int cv0 = cv_count;
        vars[1] = 8'h5A;
        do_frame(8'hA1, 1, 4);
        model_cmd(8'hA1);
        checks++;
        if (oe_in_frame !== 1'b1) begin
            failures++;
            $display("FAIL read oe: got %b expected 1", oe_in_frame);
        end
        check_frame("read_a1", 8'hA1, 1, cv0, 8'h5A, 8'h00);
    endtask

    task automatic test_invalid();
        logic [7:0] bad [0:1];
        bad[0] = 8'hA3;
        bad[1] = 8'h31;
        for (int i = 0; i < 2; i++) begin
            int cv0 = cv_count;
            do_frame(bad[i], 1, 5);
            model_cmd(bad[i]);
            check_frame("invalid", bad[i], 1, cv0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_latch();
        int cv0 = cv_count;
        vars[2]    = 8'hF0;
        change_at  = 3;
        change_idx = 2;
        change_val = 8'h0F;
        do_frame(8'hA2, 2, 4);
        change_at  = -1;
        model_cmd(8'hA2);
        check_frame("latch", 8'hA2, 2, cv0, 8'hF0, 8'h0F);
    endtask

    task automatic test_abort();
        logic [7:0] c = 8'($urandom);
        logic       m;
        int         cv0 = cv_count;
        int         n;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 3; i--) spi_bit(c[i], 4, m);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        n = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (spi_miso_oe === 1'b0) begin
                n = t;
                break;
            end
        end
        checks++;
        if (n == 0 || n > 3) begin
            failures++;
            $display("FAIL abort oe fall: got %0d clk (0=never) expected <=3", n);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (cv_count != cv0 || cmd !== ref_cmd) begin
            failures++;
            $display("FAIL abort partial: got pulses=%0d cmd=%02h expected 0/%02h",
                     cv_count - cv0, cmd, ref_cmd);
        end
        cv0 = cv_count;
        vars[0] = 8'($urandom);
        do_frame(8'hA0, 1, 4);
        model_cmd(8'hA0);
        check_frame("abort_next", 8'hA0, 1, cv0, vars[0], 8'h00);
    endtask

    task automatic test_sclk_cs_high();
        int cv0 = cv_count;
        bit oe_low = 1'b1;
        for (int i = 0; i < 12; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
            if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) oe_low = 1'b0;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!oe_low || cv_count != cv0 || cmd !== ref_cmd || var_sel !== ref_sel) begin
            failures++;
            $display("FAIL cs_high sclk: got oe_ok=%b pulses=%0d cmd=%02h sel=%0d expected 1/0/%02h/%0d",
                     oe_low, cv_count - cv0, cmd, var_sel, ref_cmd, ref_sel);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [7:0] c;
            int         nb  = $urandom_range(1, 2);
            int         hp  = (it < 5) ? 4 : $urandom_range(4, 7);
            int         cv0 = cv_count;
            logic [7:0] e;
            case ($urandom_range(0, 4))
                0:       c = 8'hA0;
                1:       c = 8'hA1;
                2:       c = 8'hA2;
                3:       c = 8'hA3;
                default: c = 8'($urandom);
            endcase
            for (int i = 0; i < 3; i++) vars[i] = 8'($urandom);
            do_frame(c, nb, hp);
            model_cmd(c);
            e = model_is_read(c) ? vars[ref_sel] : 8'h00;
            check_frame("random", c, nb, cv0, e, e);
        end
    endtask

    initial begin
        test_reset();
        test_midframe_reset();
        test_valid_read();
        test_invalid();
        test_latch();
        test_abort();
        test_sclk_cs_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_var_slave.md
# spi_var_slave

SPI mode-0 slave front end for the MAX1000 board's SPI readout path. It receives a one-byte command from the external master and decodes a 2-bit variable select that drives the 8-bit 3-to-1 variable multiplexer. It then serialises the multiplexer's selected byte back to the master on MISO. All SPI pins are oversampled in the 50 MHz system clock domain; SCLK is never used as a clock.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flip-flops per SPI input (≥2).
- CMD_PREFIX, 6'b101000: upper six command bits required for a valid read command (0xA0–0xA2).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- spi_sclk  in  1  SPI clock from master, asynchronous; idle low.
- spi_cs_n  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  master data out, asynchronous.
- spi_miso  out  1  slave data out.
- spi_miso_oe  out  1  high while a frame is active (pad tristate control).
- var_sel  out  2  select to the 3-to-1 mux (0=in1, 1=in2, 2=in3).
- var_data  in  8  mux output byte.
- cmd_valid  out  1  one-clk pulse when a command byte completes.
- cmd  out  8  last received command byte.

## Operation
- Reset values:
  - spi_miso=0, spi_miso_oe=0, var_sel=0, cmd_valid=0, cmd=0x00.
  - State WAIT_IDLE; bit counter 0.
- FSM states WAIT_IDLE, IDLE, CMD, DATA, IGNORE.
- WAIT_IDLE:
  - Go to IDLE once synchronized cs_n is seen high.
  - Prevents a reset released mid-frame from decoding a partial frame.
- IDLE:
  - On a cs_n falling event, go to CMD.
  - Clear the bit counter and the rx shift register.
- CMD:
  - Sample MOSI on each SCLK rising event, MSB first.
  - After the 8th rising event, cmd takes the byte and cmd_valid pulses.
  - If cmd[7:2]==CMD_PREFIX and cmd[1:0]!=3: var_sel=cmd[1:0], go to DATA.
  - Otherwise go to IGNORE; var_sel is unchanged.
- DATA:
  - On each SCLK falling event with bit counter 0, load the tx shift register from var_data.
  - On that load event, drive bit7 on MISO.
  - On subsequent falling events, shift; MISO = the next bit, MSB first.
  - The counter wraps mod 8, so the same variable is re-sampled and streamed until cs_n rises.
- IGNORE: spi_miso=0; wait for cs_n rising.
- In any state, a cs_n rising event:
  - Go to IDLE; spi_miso=0, spi_miso_oe=0.
  - var_sel and cmd are retained.
  - A partial byte is discarded without a cmd_valid pulse.
- spi_miso_oe=1 in CMD, DATA and IGNORE. spi_miso is 0 in CMD.
- SCLK edges while cs_n is high are ignored.

## Timing
- Each SPI pin passes through SYNC_STAGES flip-flops plus one edge-detect register.
- Pin-to-event latency is SYNC_STAGES+1 clk (3 clk at default).
- cmd_valid and var_sel are registered: they update 1 clk after the 8th SCLK rising event.
- var_data sampling:
  - Sampled on the first falling event of DATA, at least 4 clk after var_sel changes.
  - var_data is combinational from var_sel, so it is settled by then.
- MISO update is 1 clk after the falling event.
- MISO total delay after the SCLK pin falls is ≤ SYNC_STAGES+2 clk (80 ns at default).
- Maximum SCLK is clk/8 (6.25 MHz), with high and low phases each ≥4 clk.
- cs_n setup before the first SCLK rise is ≥4 clk.
- Simultaneous events in the same clk: cs_n rising wins over any SCLK event.

## Structure
- Package spi_var_pkg holds:
  - the state enum;
  - the CMD_PREFIX default;
  - the VAR_W=8 and SEL_W=2 constants;
  - the VAR_SEL_MAX=2 constant.
- Sub-module spi_sync_edge: parameterised SYNC_STAGES synchronizer with rise/fall event outputs.
  - One instance each for spi_sclk and spi_cs_n.
  - spi_mosi uses the synchronizer output only.

## Test plan
- Reset asserted mid-frame (cs_n low, 3 bits shifted), then released with cs_n still low; continue clocking:
  - no cmd_valid, MISO stays 0, var_sel=0;
  - the next full frame after cs_n high works normally.
- Frame 0xA1 then 8 clocks, var_data=0x5A when var_sel=1:
  - cmd=0xA1, cmd_valid pulses once, var_sel=1;
  - MISO bits 0,1,0,1,1,0,1,0.
- Frame 0xA3 (select 3) and frame 0x31 (bad prefix):
  - cmd_valid pulses, var_sel keeps its prior value;
  - MISO=0 for all data clocks.
- Frame 0xA2 with 16 data clocks, var_data changed from 0xF0 to 0x0F after bit 3:
  - first byte reads 0xF0 (latched), second byte reads 0x0F.
- cs_n deasserted after 5 command bits:
  - no cmd_valid, spi_miso_oe falls within 3 clk;
  - a following 0xA0 frame decodes correctly.
- SCLK toggling with cs_n high, SCLK at the clk/8 limit:
  - no state change while cs_n is high;
  - all bits captured correctly at the limit rate.
